multi_port_ram_ctrl: RTL and testbench

//  NUM_PORTS-port synchronous RAM with independent valid/ready address, write-data and

---
 rtl/multi_port_ram_ctrl.sv | 142 ++++++++++++++
 tb/tb_multi_port_ram_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_port_ram_ctrl.sv
// NUM_PORTS-port RAM controller: per-port valid/ready address, write and read channels,
// round-robin same-address write arbitration, one buffered read response per port.
// Optional RAM_WRITE_FIRST_EN: same-cycle read of a written address returns the new data.
module multi_port_ram_ctrl #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int DEPTH      = 256
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            en,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_PORTS-1:0]            we,
  input  logic [NUM_PORTS-1:0]            addr_valid,
  output logic [NUM_PORTS-1:0]            addr_ready,
  input  logic [NUM_PORTS*BUS_WIDTH-1:0]  data_in,
  input  logic [NUM_PORTS-1:0]            valid_w,
  output logic [NUM_PORTS-1:0]            ready_w,
  output logic [NUM_PORTS*BUS_WIDTH-1:0]  data_out,
  output logic [NUM_PORTS-1:0]            valid_r,
  input  logic [NUM_PORTS-1:0]            ready_r,
  output logic [NUM_PORTS-1:0]            resp_err,
  output logic [NUM_PORTS-1:0]            dbg_slot_full,
  output logic [2:0]                      dbg_rr_ptr
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
`ifdef RAM_WRITE_FIRST_EN
  localparam bit WRITE_FIRST = 1'b1;
`else
  localparam bit WRITE_FIRST = 1'b0;
`endif

  // Handshake: a channel transfers on a rising edge where valid and ready are both high.
  // addr_ready/ready_w are combinational and always assert together for writes.
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_e;

  slot_e                 r_state     [NUM_PORTS];
  slot_e                 w_state_nxt [NUM_PORTS];
  logic [BUS_WIDTH-1:0]  r_mem       [DEPTH];
  logic [BUS_WIDTH-1:0]  r_data      [NUM_PORTS];
  logic [NUM_PORTS-1:0]  r_err;
  logic [2:0]            r_rr_ptr;

  logic [ADDR_WIDTH-1:0] w_addr    [NUM_PORTS];
  logic [BUS_WIDTH-1:0]  w_wdata   [NUM_PORTS];
  logic [BUS_WIDTH-1:0]  w_rd_data [NUM_PORTS];
  logic [2:0]            w_dist    [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_in_range, w_wr_req, w_lost, w_beats, w_wr_acc, w_rd_acc, w_drain;
  logic [3:0]            w_best;
  logic [2:0]            w_rr_next;
  logic                  w_en;

  always_comb begin
    w_en      = en & aresetn;
    w_best    = 4'd8;
    w_rr_next = r_rr_ptr;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_addr[p]     = addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      w_wdata[p]    = data_in[p*BUS_WIDTH +: BUS_WIDTH];
      w_in_range[p] = ({1'b0, w_addr[p]} < DEPTH_EXT);
      w_wr_req[p]   = w_en & addr_valid[p] & we[p] & valid_w[p];
      w_dist[p]     = 3'((p + NUM_PORTS - int'(r_rr_ptr)) % NUM_PORTS);
    end
    // A requester loses if another in-range writer to the same word sits closer to rr_ptr.
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_lost[p] = 1'b0;
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (q != p && w_wr_req[p] && w_wr_req[q] && w_in_range[p] &&
            w_addr[q] == w_addr[p] && w_dist[q] < w_dist[p])
          w_lost[p] = 1'b1;
      end
    end
    w_wr_acc = w_wr_req & ~w_lost;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_beats[p] = 1'b0;
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (q != p && w_lost[q] && w_addr[q] == w_addr[p])
          w_beats[p] = 1'b1;
      end
      if (w_wr_acc[p] && w_beats[p] && {1'b0, w_dist[p]} < w_best) begin
        w_best    = {1'b0, w_dist[p]};
        w_rr_next = (p == NUM_PORTS-1) ? 3'd0 : 3'(p + 1);
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_drain[p]     = (r_state[p] == SLOT_FULL) & ready_r[p];
      w_rd_acc[p]    = w_en & addr_valid[p] & ~we[p] & ((r_state[p] == SLOT_EMPTY) | w_drain[p]);
      w_rd_data[p]   = w_in_range[p] ? r_mem[w_addr[p][IDXW-1:0]] : '0;
      // At most one writer per in-range word is accepted, so the bypass is unambiguous.
      for (int q = 0; q < NUM_PORTS; q++) begin
        if (WRITE_FIRST && w_wr_acc[q] && w_in_range[p] && w_addr[q] == w_addr[p])
          w_rd_data[p] = w_wdata[q];
      end
      w_state_nxt[p] = r_state[p];
      case (r_state[p])
        SLOT_EMPTY: if (w_rd_acc[p]) w_state_nxt[p] = SLOT_FULL;
        SLOT_FULL:  if (w_rd_acc[p]) w_state_nxt[p] = SLOT_FULL;
                    else if (w_drain[p]) w_state_nxt[p] = SLOT_EMPTY;
        default:    w_state_nxt[p] = SLOT_EMPTY;
      endcase
      valid_r[p]                        = (r_state[p] == SLOT_FULL);
      data_out[p*BUS_WIDTH +: BUS_WIDTH] = r_data[p];
    end
    addr_ready    = w_wr_acc | w_rd_acc;
    ready_w       = w_wr_acc;
    resp_err      = r_err;
    dbg_slot_full = valid_r;
    dbg_rr_ptr    = r_rr_ptr;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_state[p] <= SLOT_EMPTY;
        r_data[p]  <= '0;
      end
      r_err    <= '0;
      r_rr_ptr <= 3'd0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_state[p] <= w_state_nxt[p];
        if (w_rd_acc[p]) begin
          r_data[p] <= w_rd_data[p];
          r_err[p]  <= ~w_in_range[p];
        end
      end
      r_rr_ptr <= w_rr_next;
    end
  end

  // Storage is deliberately not reset; out-of-range writes are accepted and dropped here.
  always_ff @(posedge aclk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_wr_acc[p] && w_in_range[p])
        r_mem[w_addr[p][IDXW-1:0]] <= w_wdata[p];
    end
  end

endmodule

// File: tb/tb_multi_port_ram_ctrl.sv
// Directed bench for multi_port_ram_ctrl (2 ports, DEPTH 256) with a queue-based response scoreboard.
module tb_multi_port_ram_ctrl;
  localparam int NP = 2;
  localparam int AW = 32;
  localparam int BW = 64;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              en;
  logic [NP*AW-1:0]  addr;
  logic [NP-1:0]     we, addr_valid, addr_ready, valid_w, ready_w, valid_r, ready_r, resp_err, dbg_slot_full;
  logic [NP*BW-1:0]  data_in, data_out;
  logic [2:0]        dbg_rr_ptr;

  int n_vec = 0;
  int n_err = 0;
  logic [BW:0] exp_q0[$];
  logic [BW:0] exp_q1[$];

`ifdef RAM_WRITE_FIRST_EN
  localparam logic [63:0] T5_EXP = 64'h55;
`else
  localparam logic [63:0] T5_EXP = 64'h11;
`endif

  multi_port_ram_ctrl #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .BUS_WIDTH(BW), .DEPTH(256)) dut (
    .aclk(aclk), .aresetn(aresetn), .en(en), .addr(addr), .we(we),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .data_in(data_in),
    .valid_w(valid_w), .ready_w(ready_w), .data_out(data_out), .valid_r(valid_r),
    .ready_r(ready_r), .resp_err(resp_err), .dbg_slot_full(dbg_slot_full),
    .dbg_rr_ptr(dbg_rr_ptr)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [BW:0] act, input logic [BW:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [BW-1:0] d);
    addr_valid[p]      = v;
    we[p]              = w;
    valid_w[p]         = v & w;
    addr[p*AW +: AW]   = a;
    data_in[p*BW +: BW] = d;
  endtask

  task automatic push(input int p, input logic e, input logic [BW-1:0] d);
    if (p == 0) exp_q0.push_back({e, d});
    else        exp_q1.push_back({e, d});
  endtask

  task automatic wr1(input int p, input logic [AW-1:0] a, input logic [BW-1:0] d);
    drive(p, 1'b1, 1'b1, a, d);
    @(negedge aclk);
    chk("wr_accept", {63'd0, addr_ready[p], ready_w[p]}, 65'd3);
    tick();
    drive(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic rd1(input int p, input logic [AW-1:0] a, input logic e, input logic [BW-1:0] d);
    push(p, e, d);
    drive(p, 1'b1, 1'b0, a, '0);
    @(negedge aclk);
    chk("rd_accept", {63'd0, addr_ready[p], ready_w[p]}, 65'd2);
    tick();
    drive(p, 1'b0, 1'b0, '0, '0);
    chk("rd_latency", valid_r[p], 1);
  endtask

  // Response monitor: a response is consumed on each edge where valid_r & ready_r.
  always @(negedge aclk) begin : mon
    logic [BW:0] got;
    if (aresetn) begin
      for (int p = 0; p < NP; p++) begin
        if (valid_r[p] && ready_r[p]) begin
          got = {resp_err[p], data_out[p*BW +: BW]};
          if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0))
            chk("unexpected_resp", got, '1);
          else if (p == 0)
            chk("resp_p0", got, exp_q0.pop_front());
          else
            chk("resp_p1", got, exp_q1.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; en = 1'b1; addr = '0; we = '0; addr_valid = '0;
    data_in = '0; valid_w = '0; ready_r = 2'b11;
    #12;
    chk("rst_addr_ready", addr_ready, 0);
    chk("rst_ready_w", ready_w, 0);
    chk("rst_valid_r", valid_r, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_data_out", data_out[BW-1:0] | data_out[2*BW-1:BW], 0);
    chk("rst_rr_ptr", dbg_rr_ptr, 0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    tick();

    wr1(0, 32'h31, 64'h3131);
    wr1(0, 32'h32, 64'h3232);
    wr1(0, 32'h2C, 64'h2C2C);
    wr1(0, 32'h40, 64'h11);

    // T1: write then read on another port
    wr1(0, 32'h10, 64'hDEAD_BEEF);
    rd1(1, 32'h10, 1'b0, 64'hDEAD_BEEF);

    // T2: same-address collisions, rr_ptr starts at 0
    drive(0, 1'b1, 1'b1, 32'h20, 64'hA);
    drive(1, 1'b1, 1'b1, 32'h20, 64'hB);
    @(negedge aclk);
    chk("t2_ar_first", addr_ready, 2'b01);
    chk("t2_rw_first", ready_w, 2'b01);
    tick();
    chk("t2_rr_after1", dbg_rr_ptr, 1);
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge aclk);
    chk("t2_ar_loser", addr_ready, 2'b10);
    tick();
    drive(1, 1'b0, 1'b0, '0, '0);
    chk("t2_rr_nocoll", dbg_rr_ptr, 1);
    rd1(0, 32'h20, 1'b0, 64'hB);
    drive(0, 1'b1, 1'b1, 32'h20, 64'hC);
    drive(1, 1'b1, 1'b1, 32'h20, 64'hD);
    @(negedge aclk);
    chk("t2_ar_second", addr_ready, 2'b10);
    tick();
    chk("t2_rr_after2", dbg_rr_ptr, 0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge aclk);
    chk("t2_ar_loser2", addr_ready, 2'b01);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    rd1(1, 32'h20, 1'b0, 64'hC);

    // T3: back-pressure holds the slot and blocks further reads
    wr1(0, 32'h30, 64'h3030);
    ready_r[0] = 1'b0;
    rd1(0, 32'h30, 1'b0, 64'h3030);
    push(0, 1'b0, 64'h3131);
    drive(0, 1'b1, 1'b0, 32'h31, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("t3_hold_valid", valid_r[0], 1);
      chk("t3_hold_data", data_out[BW-1:0], 64'h3030);
      chk("t3_blocked", addr_ready[0], 0);
      tick();
    end
    ready_r[0] = 1'b1;
    @(negedge aclk);
    chk("t3_drain_accept", addr_ready[0], 1);
    tick();
    push(0, 1'b0, 64'h3232);
    drive(0, 1'b1, 1'b0, 32'h32, '0);
    @(negedge aclk);
    chk("t3_b2b_accept", addr_ready[0], 1);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);

    // T4: out of range and global enable
    rd1(0, 32'd300, 1'b1, 64'h0);
    wr1(0, 32'd300, 64'hBAD);
    rd1(0, 32'h2C, 1'b0, 64'h2C2C);
    rd1(1, 32'h1000_0010, 1'b1, 64'h0);
    push(0, 1'b0, 64'h3131);
    en = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h31, '0);
    @(negedge aclk);
    chk("en_off_blocked", addr_ready[0], 0);
    tick();
    en = 1'b1;
    @(negedge aclk);
    chk("en_on_accept", addr_ready[0], 1);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);

    // T5: same-cycle write and read of one address
    drive(0, 1'b1, 1'b1, 32'h40, 64'h55);
    push(1, 1'b0, T5_EXP);
    drive(1, 1'b1, 1'b0, 32'h40, '0);
    @(negedge aclk);
    chk("t5_both_accept", addr_ready, 2'b11);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    rd1(0, 32'h40, 1'b0, 64'h55);

    // T6: reset while a response is pending
    drive(0, 1'b1, 1'b1, 32'h50, 64'h5A);
    drive(1, 1'b1, 1'b1, 32'h50, 64'h5B);
    @(negedge aclk);
    chk("t6_coll", addr_ready, 2'b01);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    chk("t6_rr_set", dbg_rr_ptr, 1);
    ready_r[0] = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h10, '0);
    @(negedge aclk);
    chk("t6_rd_accept", addr_ready[0], 1);
    tick();
    drive(0, 1'b0, 1'b0, '0, '0);
    chk("t6_pending", valid_r[0], 1);
    drive(1, 1'b1, 1'b1, 32'h51, 64'h77);
    #2;
    chk("t6_pre_rst_ar", addr_ready[1], 1);
    aresetn = 1'b0;
    #1;
    chk("t6_valid_r", valid_r, 0);
    chk("t6_addr_ready", addr_ready, 0);
    chk("t6_ready_w", ready_w, 0);
    chk("t6_rr_ptr", dbg_rr_ptr, 0);
    chk("t6_data_out", data_out[BW-1:0], 0);
    drive(1, 1'b0, 1'b0, '0, '0);
    ready_r = 2'b11;
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    rd1(1, 32'h50, 1'b0, 64'h5A);

    tick();
    tick();
    chk("q0_drained", exp_q0.size(), 0);
    chk("q1_drained", exp_q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
